// File: rtl/pos_sweep_engine.sv
// pos_sweep_engine
//   Product-of-sums evaluator with a live lookup path and a sweep engine.
//   The live path registers F = ~maxterm_mask[in] (and its complement) every
//   clock. On start, the sweep engine snapshots the mask and walks all 2^N
//   combinations, one per cycle, counting those where F = 1.
//
//   Optional feature: define POS_SWEEP_TRACE_EN to add the sweep_idx / sweep_F
//   trace ports.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active high
//   in           : live input combination (bit N-1 = MSB of index)
//   maxterm_mask : bit i = 1 -> F = 0 at combination i
//   start        : sweep request, honoured only in IDLE
//   F, Fn        : registered live function value and its complement
//   busy         : high for the 2^N sweep cycles
//   done         : one-cycle pulse after the last sweep cycle
//   ones_count   : number of combinations with F = 1 (held until next start)
//   sweep_idx    : (trace) combination being evaluated, 0 outside a sweep
//   sweep_F      : (trace) F at sweep_idx, 0 outside a sweep
module pos_sweep_engine #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in,
  input  logic [(1<<N)-1:0] maxterm_mask,
  input  logic              start,
  output logic              F,
  output logic              Fn,
  output logic              busy,
  output logic              done,
  output logic [N:0]        ones_count
`ifdef POS_SWEEP_TRACE_EN
  ,
  output logic [N-1:0]      sweep_idx,
  output logic              sweep_F
`endif
);

  localparam int M = 1 << N;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q;
  logic [M-1:0]   mask_q;
  logic           cur_one;
  logic           last_idx;

  // Sweep works on the snapshot so mask changes mid-sweep are invisible.
  assign cur_one  = ~mask_q[idx_q];
  assign last_idx = (idx_q == '1);

  // Live path: independent of the sweep FSM, uses the live mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F  <= 1'b0;
      Fn <= 1'b1;
    end else begin
      F  <= ~maxterm_mask[in];
      Fn <=  maxterm_mask[in];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (last_idx) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep datapath. ones_count is N+1 bits so an all-zero mask reaches 2^N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      mask_q     <= '0;
      ones_count <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mask_q     <= maxterm_mask;
          idx_q      <= '0;
          ones_count <= '0;
        end
        SWEEP: begin
          ones_count <= ones_count + {{N{1'b0}}, cur_one};
          if (!last_idx) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef POS_SWEEP_TRACE_EN
  assign sweep_idx = (state_q == SWEEP) ? idx_q : '0;
  assign sweep_F   = (state_q == SWEEP) & cur_one;
`endif

endmodule

// File: tb/tb_pos_sweep_engine.sv
// tb_pos_sweep_engine
//   Scoreboard bench for pos_sweep_engine (N = 3). The driver pushes the
//   expected live value and, for each start the reference model accepts, the
//   expected sweep outcome; a negedge monitor pops and compares.
module tb_pos_sweep_engine;
  localparam int N = 3;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst_s;
  logic [N-1:0] in_s;
  logic [M-1:0] mask_s;
  logic         start_s;
  logic         f_o, fn_o, busy_o, done_o;
  logic [N:0]   ones_o;
`ifdef POS_SWEEP_TRACE_EN
  logic [N-1:0] sidx_o;
  logic         sf_o;
`endif

  pos_sweep_engine #(.N(N)) dut (
    .clk(clk), .rst(rst_s), .in(in_s), .maxterm_mask(mask_s), .start(start_s),
    .F(f_o), .Fn(fn_o), .busy(busy_o), .done(done_o), .ones_count(ones_o)
`ifdef POS_SWEEP_TRACE_EN
    , .sweep_idx(sidx_o), .sweep_F(sf_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; int f; } lv_t;
  typedef struct { int due; int ones; logic [M-1:0] mask; } sw_t;

  lv_t lq[$];
  sw_t swq[$];
  int  cyc = 0;
  int  next_acc = 0;
  int  last_ones = 0;
  int  tests = 0;
  int  fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: number of combinations whose maxterm is absent.
  function automatic int zeros(input logic [M-1:0] m);
    int c = 0;
    for (int i = 0; i < M; i++) if (!m[i]) c++;
    return c;
  endfunction

  // Inputs change 1ns after a rising edge and are sampled at the next one.
  task automatic drive(input logic [N-1:0] i, input logic [M-1:0] m, input logic s);
    sw_t e;
    @(posedge clk); #1;
    in_s = i; mask_s = m; start_s = s;
    lq.push_back('{cyc + 1, m[i] ? 0 : 1});
    if (s && (cyc + 1 >= next_acc)) begin
      e.due = cyc + 1 + M; e.ones = zeros(m); e.mask = m;
      swq.push_back(e);
      next_acc = cyc + 1 + M + 2;
    end
  endtask

  task automatic rnd_drive(input logic [M-1:0] m, input logic s);
    logic [31:0] r;
    r = $urandom();
    drive(r[N-1:0], m, s);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_s = 1'b1; start_s = 1'b0;
    lq.delete(); swq.delete();
    #1;
    chk("rst_F", int'(f_o), 0);
    chk("rst_Fn", int'(fn_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_ones", int'(ones_o), 0);
    @(posedge clk); #1;
    rst_s = 1'b0;
    next_acc = 0; last_ones = 0;
  endtask

  // Monitor: pops live and sweep expectations when they fall due.
  always @(negedge clk) begin
    lv_t l;
    bit  exp_busy;
    if (!rst_s) begin
      while (lq.size() > 0 && lq[0].due <= cyc) begin
        l = lq.pop_front();
        if (l.due == cyc) begin
          chk("live_F", int'(f_o), l.f);
          chk("live_Fn", int'(fn_o), 1 - l.f);
        end
      end
      exp_busy = (swq.size() > 0) && (cyc >= swq[0].due - M) && (cyc < swq[0].due);
      chk("busy", int'(busy_o), int'(exp_busy));
`ifdef POS_SWEEP_TRACE_EN
      if (exp_busy) begin
        chk("trace_idx", int'(sidx_o), cyc - (swq[0].due - M));
        chk("trace_F", int'(sf_o), swq[0].mask[cyc - (swq[0].due - M)] ? 0 : 1);
      end else begin
        chk("trace_idx_idle", int'(sidx_o), 0);
        chk("trace_F_idle", int'(sf_o), 0);
      end
`endif
      if (swq.size() > 0 && swq[0].due == cyc) begin
        chk("done", int'(done_o), 1);
        chk("ones_count", int'(ones_o), swq[0].ones);
        last_ones = swq[0].ones;
        void'(swq.pop_front());
      end else begin
        chk("no_done", int'(done_o), 0);
        if (!exp_busy) chk("ones_hold", int'(ones_o), last_ones);
      end
    end
  end

  initial begin
    logic [31:0] r;
    rst_s = 1'b1; in_s = '0; mask_s = '0; start_s = 1'b0;
    do_reset();

    // Live path stepping through every combination.
    for (int i = 0; i < M; i++) drive(N'(i), 8'hC5, 1'b0);

    // Basic sweep plus the all-absent and all-present mask boundaries.
    drive('0, 8'hC5, 1'b1);
    repeat (M + 3) rnd_drive(8'hC5, 1'b0);
    drive('0, 8'h00, 1'b1);
    repeat (M + 3) rnd_drive(8'h00, 1'b0);
    drive('0, 8'hFF, 1'b1);
    repeat (M + 3) rnd_drive(8'hFF, 1'b0);

    // Mask change and stray start in mid-sweep are ignored.
    drive('0, 8'hC5, 1'b1);
    repeat (3) rnd_drive(8'hC5, 1'b0);
    drive('0, 8'h00, 1'b1);
    repeat (M + 3) rnd_drive(8'h00, 1'b0);

    // Reset mid-sweep aborts with no done; the next start is served.
    drive('0, 8'hC5, 1'b1);
    repeat (5) rnd_drive(8'hC5, 1'b0);
    do_reset();
    drive('0, 8'hC5, 1'b1);
    repeat (M + 3) rnd_drive(8'hC5, 1'b0);

    // start held high: back-to-back sweeps with a fresh mask each time.
    repeat (3 * (M + 2) + 1) begin
      r = $urandom();
      rnd_drive(r[M-1:0], 1'b1);
    end
    repeat (M + 3) rnd_drive(8'h5A, 1'b0);

    // Randomized traffic with occasional resets.
    repeat (600) begin
      r = $urandom();
      if ($urandom_range(0, 79) == 0) do_reset();
      else rnd_drive(r[M-1:0], ($urandom_range(0, 3) == 0));
    end
    repeat (M + 3) rnd_drive(8'h00, 1'b0);

    @(posedge clk); @(negedge clk); #1;
    chk("sweep_queue_drained", swq.size(), 0);
    chk("live_queue_drained", lq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pos_sweep_engine.md
POS_SWEEP_ENGINE -- requirements
Module: pos_sweep_engine

Interface
REQ-001 SHALL have parameter N, default 3, range 1..8: number of function inputs.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in, input, N: live input combination; bit N-1 is the MSB of the index (x for N=3).
REQ-005 SHALL have port maxterm_mask, input, 2^N: bit i=1 means F=0 at combination i (maxterm i present).
REQ-006 SHALL have port start, input, 1: sweep request.
REQ-007 SHALL have port F, output, 1: registered POS value for in.
REQ-008 SHALL have port Fn, output, 1: registered complement of F.
REQ-009 SHALL have port busy, output, 1: sweep in progress.
REQ-010 SHALL have port done, output, 1: one-cycle sweep-complete pulse.
REQ-011 SHALL have port ones_count, output, N+1: number of combinations where F=1.
REQ-012 SHALL have port sweep_idx, output, N, present only under POS_SWEEP_TRACE_EN: combination currently evaluated.
REQ-013 SHALL have port sweep_F, output, 1, present only under POS_SWEEP_TRACE_EN: F at sweep_idx.

Function
REQ-014 Live path SHALL register F = ~maxterm_mask[in] and Fn = maxterm_mask[in] every clock; latency 1 cycle.
REQ-015 Live path SHALL use the live maxterm_mask port and SHALL run independently of sweep state.
REQ-016 FSM SHALL have states IDLE, SWEEP, DONE.
REQ-017 In IDLE with start=1: latch maxterm_mask into mask_q, clear idx and ones_count, go to SWEEP.
REQ-018 In SWEEP, each cycle: ones_count += ~mask_q[idx]; if idx = 2^N-1 go to DONE, else idx++.
REQ-019 In DONE: done=1 for exactly that cycle, then go to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly in SWEEP, i.e. 2^N consecutive cycles after start acceptance; done SHALL follow in the next cycle.
REQ-021 start SHALL be ignored in SWEEP and DONE; no queuing.
REQ-022 Changes to maxterm_mask during SWEEP SHALL NOT affect ones_count.
REQ-023 ones_count SHALL be N+1 bits so an all-zero mask yields 2^N without wrap; idx SHALL NOT wrap past 2^N-1.
REQ-024 ones_count SHALL hold its final value from DONE until the next accepted start.
REQ-025 start held high continuously SHALL launch a new sweep every 2^N+2 cycles: accept, SWEEP, DONE, then accept again in IDLE.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, idx=0, ones_count=0, busy=0, done=0, F=0, Fn=1 (sweep_idx=0, sweep_F=0 when present).
REQ-027 rst asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after deassertion SHALL be served normally.

Configuration
REQ-028 Macro POS_SWEEP_TRACE_EN defined: sweep_idx = idx and sweep_F = ~mask_q[idx] SHALL be driven combinationally while in SWEEP, and SHALL be 0 otherwise.
REQ-029 Macro POS_SWEEP_TRACE_EN undefined: sweep_idx and sweep_F ports and their logic SHALL be absent; all other behaviour is identical.

Verification (N=3 unless stated)
REQ-030 mask=0xC5, in stepped 0..7 one per cycle -> F one cycle later = 0,1,0,1,1,1,0,0; Fn always equals ~F.
REQ-031 mask=0xC5, pulse start -> busy high exactly 8 cycles, done single pulse next cycle, ones_count=4.
REQ-032 mask=0x00 -> ones_count=8 (4'b1000); mask=0xFF -> ones_count=0.
REQ-033 mask=0xC5, start; at sweep cycle 3 set mask=0x00 and pulse start -> ones_count still 4, exactly one done pulse.
REQ-034 rst pulse at sweep cycle 5 -> busy=0, ones_count=0, F=0, Fn=1, no done; next start with 0xC5 -> 4.
REQ-035 POS_SWEEP_TRACE_EN defined, mask=0xC5 -> sweep_idx 0..7 over the 8 busy cycles, sweep_F = 0,1,0,1,1,1,0,0.
